// File: rtl/mem_if_pkg.sv
// Shared types and widths for the cache memory-port responder.
// Not a timed block; no latency or flow-control behaviour of its own.
package mem_if_pkg;

    localparam int BLOCK_W = 128;
    localparam int MEM_AW  = 28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/mem_block_array.sv
// Single-port block RAM, 2**AW x BLOCK_W, registered read output.
// One-cycle read latency; rdata holds between reads; no flow control.
module mem_block_array
    import mem_if_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic               clk,
    input  logic               re,
    input  logic               we,
    input  logic [AW-1:0]      addr,
    input  logic [BLOCK_W-1:0] wdata,
    output logic [BLOCK_W-1:0] rdata
);

    logic [BLOCK_W-1:0] r_mem [0:(2**AW)-1];

    // Contents are deliberately left unreset: main memory survives a core reset.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= r_mem[addr];
        end
    end

endmodule

// File: rtl/mem_block_responder.sv
// Answers cache block read/write requests after LATENCY busy cycles with a one-cycle mem_ready.
// Request-to-ready is LATENCY+1 cycles; requests are levels held by the initiator until mem_ready.
module mem_block_responder
    import mem_if_pkg::*;
#(
    parameter int LATENCY  = 8,
    parameter int STORE_AW = 10
) (
    input  logic               clk,
    input  logic               proc_reset,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [MEM_AW-1:0]  mem_addr,
    input  logic [BLOCK_W-1:0] mem_wdata,
    output logic               mem_ready,
    output logic [BLOCK_W-1:0] mem_rdata,
    output logic               err,
    output logic [15:0]        rd_cnt,
    output logic [15:0]        wr_cnt
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_cnt;
    logic [7:0]           w_cnt_nxt;
    op_t                  r_op;
    logic [STORE_AW-1:0]  r_addr;
    logic [BLOCK_W-1:0]   r_wdata;
    logic                 r_err;
    logic                 r_rd_vld;
    logic [15:0]          r_rd_cnt;
    logic [15:0]          r_wr_cnt;

    logic                 w_req_held;
    logic                 w_accept;
    logic                 w_both;
    logic                 w_ram_re;
    logic                 w_ram_we;
    logic [BLOCK_W-1:0]   w_ram_rdata;
    logic                 w_unused_addr_hi;

    // Upper address bits alias onto the stored blocks.
    assign w_unused_addr_hi = ^mem_addr[MEM_AW-1:STORE_AW];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_both      = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_we    = 1'b0;
        w_req_held  = (r_op == OP_RD) ? mem_read : mem_write;

        case (r_state)
            IDLE: begin
                if (mem_read && mem_write) begin
                    w_both = 1'b1;
                end else if (mem_read || mem_write) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = 8'(LATENCY - 1);
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!w_req_held) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else begin
                    w_state_nxt = RESP;
                    w_ram_re    = (r_op == OP_RD);
                end
            end
            RESP: begin
                // Initiator drops its request on mem_ready, so no re-check here.
                w_state_nxt = IDLE;
                w_ram_we    = (r_op == OP_WR);
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (proc_reset) begin
            w_ram_re = 1'b0;
            w_ram_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            r_state  <= IDLE;
            r_cnt    <= 8'd0;
            r_err    <= 1'b0;
            r_rd_vld <= 1'b0;
            r_rd_cnt <= 16'd0;
            r_wr_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_both) begin
                r_err <= 1'b1;
            end
            if (w_ram_re) begin
                r_rd_vld <= 1'b1;
            end
            if (r_state == RESP) begin
                if (r_op == OP_RD) begin
                    r_rd_cnt <= r_rd_cnt + 16'd1;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op    <= mem_write ? OP_WR : OP_RD;
            r_addr  <= mem_addr[STORE_AW-1:0];
            r_wdata <= mem_wdata;
        end
    end

    mem_block_array #(
        .AW (STORE_AW)
    ) u_array (
        .clk   (clk),
        .re    (w_ram_re),
        .we    (w_ram_we),
        .addr  (r_addr),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

    // The array output register is unreset; mask it until the first real read.
    assign mem_rdata = r_rd_vld ? w_ram_rdata : '0;
    assign mem_ready = (r_state == RESP);
    assign err       = r_err;
    assign rd_cnt    = r_rd_cnt;
    assign wr_cnt    = r_wr_cnt;

endmodule

// File: tb/tb_mem_block_responder.sv
// Directed bench: one responder at LATENCY=8 for most cases, one at LATENCY=1 for the eviction pair.
module tb_mem_block_responder;

    logic         clk;
    logic         rst;
    logic         rd0, wr0, rd1, wr1;
    logic [27:0]  addr0, addr1;
    logic [127:0] wdata0, wdata1;
    logic         ready0, ready1;
    logic [127:0] rdata0, rdata1;
    logic         err0, err1;
    logic [15:0]  rd_cnt0, wr_cnt0, rd_cnt1, wr_cnt1;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    localparam logic [127:0] D1 = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    localparam logic [127:0] D2 = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hCAFE_F00D};
    localparam logic [127:0] D3 = {32'h7777_0007, 32'h7777_0006, 32'h7777_0005, 32'h7777_0004};
    localparam logic [127:0] D4 = {32'hBAD0_BAD0, 32'hBAD1_BAD1, 32'hBAD2_BAD2, 32'hBAD3_BAD3};
    localparam logic [127:0] D5 = {32'h1A1A_1A1A, 32'h0000_001A, 32'hA5A5_A5A5, 32'h5A5A_5A5A};
    localparam logic [127:0] D6 = {32'h0A0A_0A0A, 32'h0000_000A, 32'hF0F0_F0F0, 32'h0F0F_0F0F};

    mem_block_responder #(.LATENCY(8), .STORE_AW(10)) u_dut (
        .clk(clk), .proc_reset(rst), .mem_read(rd0), .mem_write(wr0),
        .mem_addr(addr0), .mem_wdata(wdata0), .mem_ready(ready0), .mem_rdata(rdata0),
        .err(err0), .rd_cnt(rd_cnt0), .wr_cnt(wr_cnt0)
    );

    mem_block_responder #(.LATENCY(1), .STORE_AW(10)) u_dut_l1 (
        .clk(clk), .proc_reset(rst), .mem_read(rd1), .mem_write(wr1),
        .mem_addr(addr1), .mem_wdata(wdata1), .mem_ready(ready1), .mem_rdata(rdata1),
        .err(err1), .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int inst, input logic rd, input logic wr,
                           input logic [27:0] a, input logic [127:0] d);
        if (inst == 0) begin
            rd0 = rd; wr0 = wr; addr0 = a; wdata0 = d;
        end else begin
            rd1 = rd; wr1 = wr; addr1 = a; wdata1 = d;
        end
    endtask

    function automatic logic ready_of(input int inst);
        return (inst == 0) ? ready0 : ready1;
    endfunction

    function automatic logic [127:0] rdata_of(input int inst);
        return (inst == 0) ? rdata0 : rdata1;
    endfunction

    // Called at a negedge; raises the request, counts cycles to mem_ready, drops it there,
    // then advances one more cycle so end-of-RESP counter updates are visible.
    task automatic xact(input int inst, input logic is_wr, input logic [27:0] a,
                        input logic [127:0] d, output int lat, output logic [127:0] rdat,
                        output int t_rdy);
        lat   = -1;
        rdat  = '0;
        t_rdy = -1;
        set_req(inst, !is_wr, is_wr, a, d);
        for (int n = 1; n <= 300; n++) begin
            step();
            if (ready_of(inst)) begin
                lat   = n;
                rdat  = rdata_of(inst);
                t_rdy = cyc;
                break;
            end
        end
        set_req(inst, 1'b0, 1'b0, a, d);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int           lat;
        int           t_rdy;
        int           c0;
        logic [127:0] rd;
        logic         seen;

        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 28'h0, '0);
        set_req(1, 1'b0, 1'b0, 28'h0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_ready",  128'(ready0),  128'd0);
        chk("rst_rdata",  rdata0,        128'd0);
        chk("rst_err",    128'(err0),    128'd0);
        chk("rst_rd_cnt", 128'(rd_cnt0), 128'd0);
        chk("rst_wr_cnt", 128'(wr_cnt0), 128'd0);

        // Write then read back, LATENCY=8.
        xact(0, 1'b1, 28'h5, D1, lat, rd, t_rdy);
        chk("wr5_lat",        128'(lat),     128'd9);
        chk("wr5_wr_cnt",     128'(wr_cnt0), 128'd1);
        chk("wr5_ready_pulse",128'(ready0),  128'd0);
        xact(0, 1'b0, 28'h5, '0, lat, rd, t_rdy);
        chk("rd5_lat",    128'(lat),     128'd9);
        chk("rd5_data",   rd,            D1);
        chk("rd5_rd_cnt", 128'(rd_cnt0), 128'd1);
        chk("rd5_hold",   rdata0,        D1);

        // Aliasing: 0x400 and 0x000 share a block.
        xact(0, 1'b1, 28'h400, D2, lat, rd, t_rdy);
        chk("wr400_lat", 128'(lat), 128'd9);
        xact(0, 1'b0, 28'h000, '0, lat, rd, t_rdy);
        chk("rd000_alias", rd, D2);

        // Abort: read dropped in BUSY cycle 3.
        seen = 1'b0;
        set_req(0, 1'b1, 1'b0, 28'h5, '0);
        repeat (3) begin
            step();
            seen |= ready0;
        end
        set_req(0, 1'b0, 1'b0, 28'h5, '0);
        step();
        seen |= ready0;
        chk("abort_no_ready", 128'(seen),    128'd0);
        chk("abort_rd_cnt",   128'(rd_cnt0), 128'd2);
        chk("abort_rdata",    rdata0,        D2);
        xact(0, 1'b0, 28'h5, '0, lat, rd, t_rdy);
        chk("after_abort_lat",  128'(lat), 128'd9);
        chk("after_abort_data", rd,        D1);

        // Protocol error: both requests high for one cycle.
        set_req(0, 1'b1, 1'b1, 28'h5, D4);
        step();
        set_req(0, 1'b0, 1'b0, 28'h5, '0);
        chk("perr_err", 128'(err0), 128'd1);
        seen = 1'b0;
        repeat (12) begin
            step();
            seen |= ready0;
        end
        chk("perr_no_ready", 128'(seen),    128'd0);
        chk("perr_sticky",   128'(err0),    128'd1);
        chk("perr_rd_cnt",   128'(rd_cnt0), 128'd3);
        chk("perr_wr_cnt",   128'(wr_cnt0), 128'd2);
        xact(0, 1'b1, 28'h7, D3, lat, rd, t_rdy);
        chk("wr7_lat",        128'(lat),  128'd9);
        chk("err_after_xact", 128'(err0), 128'd1);

        // Reset pulsed in BUSY of a write to 0x7.
        set_req(0, 1'b0, 1'b1, 28'h7, D4);
        repeat (4) step();
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 28'h7, '0);
        step();
        rst = 1'b0;
        chk("mrst_ready",  128'(ready0),  128'd0);
        chk("mrst_rdata",  rdata0,        128'd0);
        chk("mrst_err",    128'(err0),    128'd0);
        chk("mrst_rd_cnt", 128'(rd_cnt0), 128'd0);
        chk("mrst_wr_cnt", 128'(wr_cnt0), 128'd0);
        seen = 1'b0;
        repeat (10) begin
            step();
            seen |= ready0;
        end
        chk("mrst_no_ready", 128'(seen), 128'd0);
        xact(0, 1'b0, 28'h7, '0, lat, rd, t_rdy);
        chk("mrst_rd7_data", rd,            D3);
        chk("mrst_rd_cnt1",  128'(rd_cnt0), 128'd1);

        // Eviction pair on the LATENCY=1 instance.
        xact(1, 1'b1, 28'h1A, D5, lat, rd, t_rdy);
        chk("l1_pre_lat", 128'(lat), 128'd2);
        c0 = cyc;
        xact(1, 1'b1, 28'h0A, D6, lat, rd, t_rdy);
        chk("evict_wr_cycle", 128'(t_rdy - c0), 128'd2);
        xact(1, 1'b0, 28'h1A, '0, lat, rd, t_rdy);
        chk("evict_rd_cycle", 128'(t_rdy - c0), 128'd5);
        chk("evict_rd_data",  rd,               D5);
        xact(1, 1'b0, 28'h0A, '0, lat, rd, t_rdy);
        chk("evict_0a_data",  rd,               D6);
        chk("l1_wr_cnt",      128'(wr_cnt1),    128'd2);
        chk("l1_rd_cnt",      128'(rd_cnt1),    128'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
